// File: rtl/digit_serial_addsub.sv
// Purpose : signed add/sub of a and b (plus carry/borrow-in), DIGIT bits per clock
//           through one DIGIT-wide ripple slice; reports carry-out and signed
//           overflow, optionally saturating the sum.
// Latency : done pulses N = WIDTH/DIGIT edges after start is accepted; busy
//           stays high for N+1 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports   : clk, rst (sync, active-high); start/op/c_in/a/b request side;
//           busy/done status; sum/c_out/ovf results, held until the next
//           accepted start.
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // Single DIGIT-wide ripple slice; operands are shifted right each cycle so
  // the current slice always sits in the low DIGIT bits.
  logic [DIGIT:0]   slice_full;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;
  logic             slice_ovf;
  logic [WIDTH-1:0] sat_val;

  assign slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};

  // Result slices enter at the top, so after N cycles the LSB slice is at bit 0.
  assign acc_next   = (acc_q >> DIGIT)
                    | (WIDTH'(slice_full[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign last_slice = (cnt_q == CW'(N - 1));

  // Carry into the MSB equals a^b^sum at that bit, so overflow needs no extra
  // tap inside the slice (this also covers DIGIT=1).
  assign slice_ovf  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_full[DIGIT-1]
                    ^ slice_full[DIGIT];

  // On the last slice a_q[DIGIT-1] is the original sign bit of a.
  assign sat_val    = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction as a + ~b + ~c_in.
          b_d     = op ? ~b : b;
          carry_d = op ? ~c_in : c_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = slice_full[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          sum_d   = (SAT && slice_ovf) ? sat_val : acc_next;
          c_out_d = slice_full[DIGIT];
          ovf_d   = slice_ovf;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Purpose : directed and reference-model checks of digit_serial_addsub.
// Latency : 8-bit instances N=2; 16-bit instances N=16, 4, 1.
// Backpressure: none; inputs are driven and outputs sampled on the falling edge.
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit pair: wrap and saturate, shared inputs
  logic       start8 = 1'b0, op8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy_w, done_w, cout_w, ovf_w;
  logic [7:0] sum_w;
  logic       busy_s, done_s, cout_s, ovf_s;
  logic [7:0] sum_s;

  // 16-bit trio: DIGIT 1, 4, 16, shared inputs
  logic        start16 = 1'b0, op16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy_1, done_1, cout_1, ovf_1;
  logic [15:0] sum_1;
  logic        busy_4, done_4, cout_4, ovf_4;
  logic [15:0] sum_4;
  logic        busy_16, done_16, cout_16, ovf_16;
  logic [15:0] sum_16;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(4), .SAT(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .c_in(cin8), .a(a8), .b(b8),
    .busy(busy_w), .done(done_w), .sum(sum_w), .c_out(cout_w), .ovf(ovf_w));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(4), .SAT(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .c_in(cin8), .a(a8), .b(b8),
    .busy(busy_s), .done(done_s), .sum(sum_s), .c_out(cout_s), .ovf(ovf_s));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1), .SAT(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .c_in(cin16), .a(a16), .b(b16),
    .busy(busy_1), .done(done_1), .sum(sum_1), .c_out(cout_1), .ovf(ovf_1));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4), .SAT(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .c_in(cin16), .a(a16), .b(b16),
    .busy(busy_4), .done(done_4), .sum(sum_4), .c_out(cout_4), .ovf(ovf_4));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16), .SAT(1'b0)) u_d16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .c_in(cin16), .a(a16), .b(b16),
    .busy(busy_16), .done(done_16), .sum(sum_16), .c_out(cout_16), .ovf(ovf_16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation on both instances; checks latency, busy length and results.
  task automatic run8(input string tag, input logic o, input logic ci,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es_w, input logic [7:0] es_s,
                      input logic ec, input logic ev);
    int done_at, busy_n, done_n;
    logic [7:0] sw, ss;
    logic cw, vw, cs, vs;
    done_at = -1; busy_n = 0; done_n = 0;
    sw = 'x; ss = 'x; cw = 1'bx; vw = 1'bx; cs = 1'bx; vs = 1'bx;
    @(negedge clk);
    op8 = o; cin8 = ci; a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    // Scramble inputs while busy: the result must not depend on them.
    start8 = 1'b0; op8 = ~o; cin8 = ~ci; a8 = ~av; b8 = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_w) busy_n++;
      if (done_w) begin
        done_n++; done_at = k;
        sw = sum_w; cw = cout_w; vw = ovf_w;
        ss = sum_s; cs = cout_s; vs = ovf_s;
      end
    end
    chk({tag, ".lat"},    done_at, 2);
    chk({tag, ".busy"},   busy_n, 3);
    chk({tag, ".ndone"},  done_n, 1);
    chk({tag, ".sum"},    sw, es_w);
    chk({tag, ".cout"},   cw, ec);
    chk({tag, ".ovf"},    vw, ev);
    chk({tag, ".satsum"}, ss, es_s);
    chk({tag, ".satc"},   cs, ec);
    chk({tag, ".satv"},   vs, ev);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pos [3];
    int nd;
    logic [7:0] held;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy_w, 1'b0);
    chk("rst.done", done_w, 1'b0);
    chk("rst.sum",  sum_w, 8'h00);
    chk("rst.cout", cout_w, 1'b0);
    chk("rst.ovf",  ovf_w, 1'b0);
    chk("rst.busy16", busy_1, 1'b0);

    //    tag          op    cin   a      b      sum_w  sum_s  c     v
    run8("add",      1'b0, 1'b0, 8'h05, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0);
    run8("add_ovf",  1'b0, 1'b0, 8'h64, 8'h32, 8'h96, 8'h7F, 1'b0, 1'b1);
    run8("sub",      1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 8'hFE, 1'b0, 1'b0);
    run8("sub_bin",  1'b1, 1'b1, 8'h10, 8'h01, 8'h0E, 8'h0E, 1'b1, 1'b0);
    run8("sub_nsat", 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 8'h80, 1'b1, 1'b1);
    run8("add_cin",  1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 8'h7F, 1'b0, 1'b1);
    run8("add_wrap", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);

    // Results hold in IDLE.
    held = sum_w;
    repeat (4) @(negedge clk);
    chk("hold.sum", sum_w, 8'h00);
    chk("hold.stable", sum_w, held);

    // start pulsed mid-RUN with new operands is ignored.
    @(negedge clk);
    op8 = 1'b0; cin8 = 1'b0; a8 = 8'h05; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_w) nd++;
    end
    chk("ign.ndone", nd, 1);
    chk("ign.sum", sum_w, 8'h05);

    // start held high: back-to-back operations, DONE then one IDLE cycle.
    pos[0] = -100; pos[1] = -200; pos[2] = -300;
    nd = 0;
    @(negedge clk);
    op8 = 1'b0; cin8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done_w) begin
        if (nd < 3) pos[nd] = k;
        nd++;
      end
    end
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("cont.gap1", pos[1] - pos[0], 4);
    chk("cont.gap2", pos[2] - pos[1], 4);
    chk("cont.sum", sum_w, 8'h46);

    // Reset in RUN aborts and clears.
    @(negedge clk);
    a8 = 8'h64; b8 = 8'h32; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun.busy", busy_w, 1'b0);
    chk("rstrun.done", done_w, 1'b0);
    chk("rstrun.sum",  sum_w, 8'h00);
    chk("rstrun.cout", cout_w, 1'b0);
    chk("rstrun.ovf",  ovf_w, 1'b0);
    run8("after_rst", 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 8'hFE, 1'b0, 1'b0);

    // 16-bit sweep against a reference model.
    for (int v = 0; v < 24; v++) begin
      logic [15:0] av, bv, es;
      logic o, ci, ec, ev;
      logic [16:0] u;
      int r;
      int l1, l4, l16;
      logic [15:0] s1, s4, s16;
      logic c1, c4, c16, v1, v4, v16;
      av = 16'($urandom); bv = 16'($urandom);
      if (v == 0) begin av = 16'h7FFF; bv = 16'h0001; end
      if (v == 1) begin av = 16'h8000; bv = 16'h0001; end
      o = (v == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      r  = o ? ($signed(av) - $signed(bv) - int'(ci))
             : ($signed(av) + $signed(bv) + int'(ci));
      es = r[15:0];
      ev = (r > 32767) || (r < -32768);
      u  = {1'b0, av} + {1'b0, (o ? ~bv : bv)} + {16'h0, (o ? ~ci : ci)};
      ec = u[16];
      l1 = -1; l4 = -1; l16 = -1;
      s1 = 'x; s4 = 'x; s16 = 'x;
      c1 = 1'bx; c4 = 1'bx; c16 = 1'bx; v1 = 1'bx; v4 = 1'bx; v16 = 1'bx;
      @(negedge clk);
      a16 = av; b16 = bv; op16 = o; cin16 = ci; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = ~av; b16 = 16'hA5A5; op16 = ~o; cin16 = ~ci;
      for (int k = 0; k < 24; k++) begin
        if (k > 0) @(negedge clk);
        if (done_1)  begin l1  = k; s1  = sum_1;  c1  = cout_1;  v1  = ovf_1;  end
        if (done_4)  begin l4  = k; s4  = sum_4;  c4  = cout_4;  v4  = ovf_4;  end
        if (done_16) begin l16 = k; s16 = sum_16; c16 = cout_16; v16 = ovf_16; end
      end
      chk($sformatf("sw%0d.d1.lat", v),  l1, 16);
      chk($sformatf("sw%0d.d1.sum", v),  s1, es);
      chk($sformatf("sw%0d.d1.cv", v),   {c1, v1}, {ec, ev});
      chk($sformatf("sw%0d.d4.lat", v),  l4, 4);
      chk($sformatf("sw%0d.d4.sum", v),  s4, es);
      chk($sformatf("sw%0d.d4.cv", v),   {c4, v4}, {ec, ev});
      chk($sformatf("sw%0d.d16.lat", v), l16, 1);
      chk($sformatf("sw%0d.d16.sum", v), s16, es);
      chk($sformatf("sw%0d.d16.cv", v),  {c16, v16}, {ec, ev});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
